encap_hdr_parser_mc: RTL and testbench

Parametrised second-generation I/O-queue header parser for the encap/tunnel output path. It snoops the packet stream, decodes the IOQ module header's destination-port field, and queues one descriptor per packet in an internal fall-through FIFO. Each descriptor holds the destination mask, its binary port index, multicast/invalid flags, byte length, word length and source port. The block sits beside the output-queue datapath and is read by the queue writer. Compared with the first generation, it adds:
- configurable FIFO depth, queue count and field positions
- multicast and invalid-destination detection
- recovery from packets with no header
- saturating error counters

---
 rtl/encap_hdr_parser_mc_if.sv | 53 +++++
 rtl/encap_hdr_parser_mc.sv | 200 ++++++++++++++++++++
 tb/tb_encap_hdr_parser_mc.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encap_hdr_parser_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : encap_hdr_parser_mc_if
// Description : Stream-snoop input and descriptor read-out bus of the
//               encap/tunnel IOQ header parser.
// Revision    : 1.0 - initial release
// ============================================================================
interface encap_hdr_parser_mc_if #(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES  = 8,
  parameter int NUM_OQ_WIDTH       = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
  parameter int MAX_PKT            = 2048,
  parameter int PKT_BYTE_CNT_WIDTH = $clog2(MAX_PKT),
  parameter int PKT_WORD_CNT_WIDTH = $clog2(MAX_PKT / CTRL_WIDTH),
  parameter int PKT_SRC_PORT_WIDTH = 16
);

  // Packet stream being snooped
  logic                          in_wr;
  logic [CTRL_WIDTH-1:0]         in_ctrl;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          header_parser_rdy;

  // Descriptor FIFO head and pop strobe
  logic                          dst_oq_avail;
  logic                          rd_dst_oq;
  logic [NUM_OUTPUT_QUEUES-1:0]  parsed_dst_mask;
  logic [NUM_OQ_WIDTH-1:0]       parsed_dst_oq;
  logic                          parsed_multicast;
  logic                          parsed_dst_invalid;
  logic [PKT_BYTE_CNT_WIDTH-1:0] parsed_pkt_byte_len;
  logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len;
  logic [PKT_SRC_PORT_WIDTH-1:0] parsed_pkt_src_port;

  // Stream source and descriptor consumer side
  modport master (
    output in_wr, in_ctrl, in_data, rd_dst_oq,
    input  header_parser_rdy, dst_oq_avail, parsed_dst_mask, parsed_dst_oq,
           parsed_multicast, parsed_dst_invalid, parsed_pkt_byte_len,
           parsed_pkt_word_len, parsed_pkt_src_port
  );

  // Parser side
  modport slave (
    input  in_wr, in_ctrl, in_data, rd_dst_oq,
    output header_parser_rdy, dst_oq_avail, parsed_dst_mask, parsed_dst_oq,
           parsed_multicast, parsed_dst_invalid, parsed_pkt_byte_len,
           parsed_pkt_word_len, parsed_pkt_src_port
  );

endinterface
`default_nettype wire

// File: rtl/encap_hdr_parser_mc.sv
`default_nettype none
// ============================================================================
// Module      : encap_hdr_parser_mc
// Description : Snoops the packet stream, decodes the IOQ module header and
//               queues one destination/length descriptor per packet in a
//               fall-through FIFO. Counts headerless packets and headers
//               lost to a full FIFO with saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module encap_hdr_parser_mc #(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = CTRL_WIDTH'(8'hff),
  parameter int NUM_OUTPUT_QUEUES  = 8,
  parameter int NUM_OQ_WIDTH       = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
  parameter int MAX_PKT            = 2048,
  parameter int PKT_BYTE_CNT_WIDTH = $clog2(MAX_PKT),
  parameter int PKT_WORD_CNT_WIDTH = $clog2(MAX_PKT / CTRL_WIDTH),
  parameter int PKT_SRC_PORT_WIDTH = 16,
  parameter int IOQ_BYTE_LEN_POS   = 0,
  parameter int IOQ_SRC_PORT_POS   = 16,
  parameter int IOQ_WORD_LEN_POS   = 32,
  parameter int IOQ_DST_PORT_POS   = 48,
  parameter int FIFO_DEPTH_BITS    = 2,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  encap_hdr_parser_mc_if.slave bus,
  output logic [CNT_WIDTH-1:0] num_missing_hdr,
  output logic [CNT_WIDTH-1:0] num_hdr_dropped
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int OCC_W   = FIFO_DEPTH_BITS + 1;
  localparam logic [FIFO_DEPTH_BITS-1:0]   PTR_ONE  = FIFO_DEPTH_BITS'(1);
  localparam logic [OCC_W-1:0]             OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]             OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [NUM_OUTPUT_QUEUES-1:0] MASK_ONE = NUM_OUTPUT_QUEUES'(1);

  typedef enum logic [1:0] {
    WAIT_HDR  = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_EOP  = 2'd2,
    SKIP_EOP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [NUM_OUTPUT_QUEUES-1:0]  mask;
    logic [NUM_OQ_WIDTH-1:0]       oq;
    logic                          multicast;
    logic                          invalid;
    logic [PKT_BYTE_CNT_WIDTH-1:0] byte_len;
    logic [PKT_WORD_CNT_WIDTH-1:0] word_len;
    logic [PKT_SRC_PORT_WIDTH-1:0] src_port;
  } desc_t;

  state_t                     state_q, state_d;
  desc_t                      mem_q [DEPTH];
  desc_t                      mem_d [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]           count_q, count_d;
  logic [CNT_WIDTH-1:0]       missing_q, missing_d;
  logic [CNT_WIDTH-1:0]       dropped_q, dropped_d;

  logic                         is_ioq_hdr;
  logic                         is_data;
  logic                         hdr_capture;
  logic                         missing_evt;
  logic                         full;
  logic                         empty;
  logic                         wr_en;
  logic                         rd_en;
  logic [NUM_OUTPUT_QUEUES-1:0] hdr_mask;
  logic [NUM_OQ_WIDTH-1:0]      hdr_oq;
  desc_t                        new_desc;
  desc_t                        head;

  assign is_ioq_hdr = bus.in_wr && (bus.in_ctrl == IOQ_STAGE_NUM);
  assign is_data    = (bus.in_ctrl == '0);

  // Full/empty come from the registered occupancy, so a pop in the same
  // cycle never makes room for a header that arrives while full.
  assign full  = (count_q == OCC_FULL);
  assign empty = (count_q == '0);
  assign wr_en = hdr_capture && !full;
  assign rd_en = bus.rd_dst_oq && !empty;

  assign hdr_mask = bus.in_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];

  // Priority encoder: scanning from the top leaves the lowest set bit's index
  always_comb begin
    hdr_oq = '0;
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
      if (hdr_mask[i]) hdr_oq = NUM_OQ_WIDTH'(i);
    end
  end

  // Assemble the descriptor straight from the header word
  always_comb begin
    new_desc           = '0;
    new_desc.mask      = hdr_mask;
    new_desc.oq        = hdr_oq;
    new_desc.multicast = |(hdr_mask & (hdr_mask - MASK_ONE));
    new_desc.invalid   = (hdr_mask == '0);
    new_desc.byte_len  = bus.in_data[IOQ_BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH];
    new_desc.word_len  = bus.in_data[IOQ_WORD_LEN_POS +: PKT_WORD_CNT_WIDTH];
    new_desc.src_port  = bus.in_data[IOQ_SRC_PORT_POS +: PKT_SRC_PORT_WIDTH];
  end

  // Input FSM next state: first IOQ header wins, headerless packets are skipped
  always_comb begin
    state_d     = state_q;
    hdr_capture = 1'b0;
    missing_evt = 1'b0;
    case (state_q)
      WAIT_HDR: begin
        if (is_ioq_hdr) begin
          hdr_capture = 1'b1;
          state_d     = WAIT_DATA;
        end else if (bus.in_wr && is_data) begin
          missing_evt = 1'b1;
          state_d     = SKIP_EOP;
        end
      end
      WAIT_DATA: begin
        if (bus.in_wr && is_data) state_d = WAIT_EOP;
      end
      WAIT_EOP, SKIP_EOP: begin
        if (bus.in_wr && !is_data) state_d = WAIT_HDR;
      end
      default: state_d = WAIT_HDR;
    endcase
  end

  // FIFO storage, pointer and occupancy update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = new_desc;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase
  end

  // Saturating error counters
  always_comb begin
    missing_d = missing_q;
    dropped_d = dropped_q;
    if (missing_evt && (missing_q != '1)) missing_d = missing_q + CNT_ONE;
    if (hdr_capture && full && (dropped_q != '1)) dropped_d = dropped_q + CNT_ONE;
  end

  // State registers; storage is cleared too so the head never carries X
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_HDR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      missing_q <= '0;
      dropped_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      missing_q <= missing_d;
      dropped_q <= dropped_d;
      mem_q     <= mem_d;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.header_parser_rdy   = !full;
  assign bus.dst_oq_avail        = !empty;
  assign bus.parsed_dst_mask     = head.mask;
  assign bus.parsed_dst_oq       = head.oq;
  assign bus.parsed_multicast    = head.multicast;
  assign bus.parsed_dst_invalid  = head.invalid;
  assign bus.parsed_pkt_byte_len = head.byte_len;
  assign bus.parsed_pkt_word_len = head.word_len;
  assign bus.parsed_pkt_src_port = head.src_port;
  assign num_missing_hdr         = missing_q;
  assign num_hdr_dropped         = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_encap_hdr_parser_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_encap_hdr_parser_mc
// Description : Randomized scoreboard bench for encap_hdr_parser_mc
//               (16-queue build, 3-bit counters to reach saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encap_hdr_parser_mc;

  localparam int NQ    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int CSAT  = 7;

  localparam int EV_NONE = 0;
  localparam int EV_HDR  = 1;
  localparam int EV_MISS = 2;

  typedef struct {
    int unsigned mask;
    int unsigned oq;
    bit          mc;
    bit          inv;
    int unsigned blen;
    int unsigned wlen;
    int unsigned src;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] num_missing_hdr;
  logic [CW-1:0] num_hdr_dropped;

  encap_hdr_parser_mc_if #(.NUM_OUTPUT_QUEUES(NQ)) bus ();

  encap_hdr_parser_mc #(
    .NUM_OUTPUT_QUEUES (NQ),
    .FIFO_DEPTH_BITS   (2),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .num_missing_hdr (num_missing_hdr),
    .num_hdr_dropped (num_hdr_dropped)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t nil;
  int   checks = 0;
  int   errors = 0;
  int   cnt_now = 0, cnt_next = 0;
  int   miss_now = 0, miss_next = 0;
  int   drop_now = 0, drop_next = 0;
  bit   mon_en = 1'b0;
  int   rd_pct = 0;
  int   idle_pct = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference descriptor computed from the header fields
  function automatic exp_t model_desc(int unsigned mask, int unsigned blen,
                                      int unsigned wlen, int unsigned src);
    exp_t e;
    int   ones = 0;
    bit   found = 1'b0;
    e.oq = 0;
    for (int i = 0; i < NQ; i++) begin
      if (((mask >> i) & 1) == 1) begin
        ones++;
        if (!found) begin
          e.oq  = i;
          found = 1'b1;
        end
      end
    end
    e.mask = mask;
    e.mc   = (ones > 1);
    e.inv  = (mask == 0);
    e.blen = blen;
    e.wlen = wlen;
    e.src  = src;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Header word with random junk left in the unused bit ranges
  function automatic logic [63:0] make_hdr(int unsigned mask, int unsigned blen,
                                           int unsigned wlen, int unsigned src);
    logic [63:0] d;
    logic [31:0] m, b, w, s;
    d = rnd64();
    m = mask; b = blen; w = wlen; s = src;
    d[0  +: 11] = b[10:0];
    d[16 +: 16] = s[15:0];
    d[32 +: 8]  = w[7:0];
    d[48 +: 16] = m[15:0];
    return d;
  endfunction

  function automatic bit rnd_rd();
    return ($urandom_range(99) < rd_pct);
  endfunction

  // One clock of stimulus; the model predicts the state seen after this edge
  task automatic step(bit wr, logic [7:0] ctrl, logic [63:0] data, bit rd,
                      int ev, exp_t e);
    int n;
    bus.in_wr     = wr;
    bus.in_ctrl   = ctrl;
    bus.in_data   = data;
    bus.rd_dst_oq = rd;
    n         = cnt_now;
    miss_next = miss_now;
    drop_next = drop_now;
    if (ev == EV_HDR) begin
      if (cnt_now < DEPTH) begin
        sb.push_back(e);
        n++;
      end else if (drop_now < CSAT) begin
        drop_next = drop_now + 1;
      end
    end
    if (ev == EV_MISS && miss_now < CSAT) miss_next = miss_now + 1;
    if (rd && cnt_now > 0) n--;
    cnt_next = n;
    @(posedge clk);
    #1;
    cnt_now  = cnt_next;
    miss_now = miss_next;
    drop_now = drop_next;
  endtask

  task automatic idle(bit rd);
    step(1'b0, 8'($urandom), rnd64(), rd, EV_NONE, nil);
  endtask

  task automatic maybe_idle();
    if ($urandom_range(99) < idle_pct) idle(rnd_rd());
  endtask

  function automatic logic [7:0] eop_ctrl();
    return 8'(1 << $urandom_range(7));
  endfunction

  task automatic send_pkt(int unsigned mask, int unsigned blen, int unsigned wlen,
                          int unsigned src, int n_pre, int n_post, int n_data,
                          bit hdr_rd);
    logic [7:0] c;
    for (int i = 0; i < n_pre; i++) begin
      maybe_idle();
      step(1'b1, 8'($urandom_range(254, 1)), rnd64(), rnd_rd(), EV_NONE, nil);
    end
    maybe_idle();
    step(1'b1, 8'hff, make_hdr(mask, blen, wlen, src), rnd_rd() | hdr_rd, EV_HDR,
         model_desc(mask, blen, wlen, src));
    for (int i = 0; i < n_post; i++) begin
      maybe_idle();
      c = ($urandom_range(1) == 1) ? 8'hff : 8'($urandom_range(254, 1));
      step(1'b1, c, rnd64(), rnd_rd(), EV_NONE, nil);
    end
    for (int i = 0; i < n_data; i++) begin
      maybe_idle();
      step(1'b1, 8'h00, rnd64(), rnd_rd(), EV_NONE, nil);
    end
    maybe_idle();
    step(1'b1, eop_ctrl(), rnd64(), rnd_rd(), EV_NONE, nil);
  endtask

  task automatic send_missing(int n_data);
    for (int i = 0; i < n_data; i++) begin
      maybe_idle();
      step(1'b1, 8'h00, rnd64(), rnd_rd(), (i == 0) ? EV_MISS : EV_NONE, nil);
    end
    maybe_idle();
    step(1'b1, eop_ctrl(), rnd64(), rnd_rd(), EV_NONE, nil);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_wr     = 1'b0;
    bus.rd_dst_oq = 1'b0;
    sb.delete();
    cnt_next  = 0;
    miss_next = 0;
    drop_next = 0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cnt_now  = 0;
    miss_now = 0;
    drop_now = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && cnt_now > 0; k++) idle(1'b1);
  endtask

  task automatic rnd_pkt();
    int unsigned mask;
    case ($urandom_range(3))
      0:       mask = 0;
      1:       mask = 1 << $urandom_range(NQ - 1);
      default: mask = $urandom_range(16'hffff);
    endcase
    send_pkt(mask, $urandom_range(2047), $urandom_range(255), $urandom_range(65535),
             $urandom_range(2), $urandom_range(2), $urandom_range(5, 1), 1'b0);
  endtask

  // Monitor: status every cycle, descriptor contents on every pop
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("avail", bus.dst_oq_avail, cnt_now != 0);
        check("rdy", bus.header_parser_rdy, cnt_now != DEPTH);
        check("missing_cnt", num_missing_hdr, miss_now);
        check("dropped_cnt", num_hdr_dropped, drop_now);
        if (bus.rd_dst_oq && cnt_now > 0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: pop with no expected descriptor at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("dst_mask", bus.parsed_dst_mask, e.mask);
            check("dst_oq", bus.parsed_dst_oq, e.oq);
            check("multicast", bus.parsed_multicast, e.mc);
            check("dst_invalid", bus.parsed_dst_invalid, e.inv);
            check("byte_len", bus.parsed_pkt_byte_len, e.blen);
            check("word_len", bus.parsed_pkt_word_len, e.wlen);
            check("src_port", bus.parsed_pkt_src_port, e.src);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nil           = '{default: 0};
    bus.in_wr     = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.rd_dst_oq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Basic packet: dst 0x10 -> port 4
    rd_pct = 0; idle_pct = 0;
    send_pkt(16'h0010, 60, 8, 16'h0004, 0, 0, 7, 1'b0);
    drain();

    // Multicast then invalid destination
    send_pkt(16'h000c, 100, 13, 16'h0001, 1, 0, 2, 1'b0);
    send_pkt(16'h0000, 64, 8, 16'h0002, 0, 1, 2, 1'b0);
    drain();

    // Five back-to-back packets with no reads: one header dropped
    for (int i = 0; i < 5; i++) send_pkt(1 << i, 64 + i, 8 + i, i, 0, 0, 2, 1'b0);
    drain();

    // Headerless packet followed by a good one
    send_missing(4);
    send_pkt(16'h0200, 300, 38, 16'h1234, 0, 0, 3, 1'b0);
    drain();

    // Pop coinciding with a header at occupancy 3
    for (int i = 0; i < 3; i++) send_pkt(16'h0001 << i, 70, 9, 16'h00a0 + i, 0, 0, 1, 1'b0);
    send_pkt(16'h0040, 71, 10, 16'h00b0, 0, 0, 1, 1'b1);
    drain();

    // Reset in the middle of a packet; remainder counts as headerless
    send_pkt(16'h0008, 80, 10, 16'h0005, 0, 0, 1, 1'b0);
    step(1'b1, 8'hff, make_hdr(16'h0004, 90, 11, 6), 1'b0, EV_HDR, model_desc(16'h0004, 90, 11, 6));
    step(1'b1, 8'h00, rnd64(), 1'b0, EV_NONE, nil);
    do_reset();
    send_missing(3);
    send_pkt(16'h0020, 120, 15, 16'h0777, 0, 0, 2, 1'b0);
    send_pkt(16'h8000, 2047, 255, 16'hffff, 0, 0, 1, 1'b0);
    drain();

    // Counter saturation
    for (int i = 0; i < 12; i++) send_pkt(16'h0100, 64, 8, i, 0, 0, 1, 1'b0);
    for (int i = 0; i < 9; i++) send_missing(1);
    drain();
    do_reset();

    // Randomized traffic
    idle_pct = 20;
    for (int p = 0; p < 200; p++) begin
      rd_pct = ($urandom_range(3) == 0) ? 0 : 50;
      if ($urandom_range(4) == 0) send_missing($urandom_range(4, 1));
      else rnd_pkt();
    end
    rd_pct = 0;
    drain();
    repeat (2) idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
